// File: rtl/explosion_pkg.sv
// Shared types and constants for the explosion effect and the other VGA-stage blocks.
// Screen limits live here so every block clamps coordinates the same way.
package explosion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GROW   = 2'd1,
      SHRINK = 2'd2,
      ACK    = 2'd3
   } expl_state_t;

   localparam int EXPL_MAX_RADIUS = 24;
   localparam int EXPL_STEP       = 3;
   localparam int EXPL_RING_W     = 4;

   localparam int H_MAX = 639;
   localparam int V_MAX = 524;

   // Full-width compare, so huge request values still land on the screen edge.
   function automatic logic [9:0] clamp_coord(input logic [32:0] v, input logic [9:0] lim);
      return (v > {23'd0, lim}) ? lim : v[9:0];
   endfunction

endpackage

// File: rtl/explosion_effect_if.sv
// Four-phase destroy handshake between the meteor block (master) and the explosion effect (slave).
interface explosion_effect_if;

   logic        startDesClock;
   logic [32:0] dH;
   logic [32:0] dV;
   logic        desClock;
   logic        busy;

   modport master (output startDesClock, dH, dV, input desClock, busy);
   modport slave  (input startDesClock, dH, dV, output desClock, busy);

endinterface

// File: rtl/frame_pulse_detect.sv
// One-cycle frame pulse when VCounter wraps from a non-zero row back to row 0.
module frame_pulse_detect (
   input  logic       clk,
   input  logic       resetn,
   input  logic [9:0] VCounter,
   output logic       frame
);

   logic [9:0] v_prev;

   always_ff @(posedge clk) begin
      if (!resetn) v_prev <= '0;
      else         v_prev <= VCounter;
   end

   assign frame = (VCounter == 10'd0) && (v_prev != 10'd0);

endmodule

// File: rtl/explosion_effect.sv
// Expanding-then-collapsing diamond ring drawn at the latched meteor centre, acknowledged on desClock.
//
//   state  | meaning
//   IDLE   | waiting for a rising edge of startDesClock
//   GROW   | radius += STEP per frame until MAX_RADIUS
//   SHRINK | radius -= STEP per frame until 0
//   ACK    | desClock high until startDesClock drops
module explosion_effect #(
   parameter logic [9:0] MAX_RADIUS = 10'(explosion_pkg::EXPL_MAX_RADIUS),
   parameter logic [9:0] STEP       = 10'(explosion_pkg::EXPL_STEP),
   parameter logic [9:0] RING_W     = 10'(explosion_pkg::EXPL_RING_W),
   parameter logic [9:0] H_MAX      = 10'(explosion_pkg::H_MAX),
   parameter logic [9:0] V_MAX      = 10'(explosion_pkg::V_MAX)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [9:0]               HCounter,
   input  logic [9:0]               VCounter,
   output logic                     pixel,
   explosion_effect_if.slave        bus
);

   import explosion_pkg::*;

   expl_state_t state;
   logic [9:0]  radius;
   logic [9:0]  cx;
   logic [9:0]  cy;
   logic        start_q;
   logic        desclk_q;
   logic        busy_q;
   logic        frame;
   logic        start_rise;
   logic [10:0] dx;
   logic [10:0] dy;
   logic [11:0] d;
   logic [10:0] grow_next;
   logic        on_ring;

   frame_pulse_detect u_frame (
      .clk      (clk),
      .resetn   (resetn),
      .VCounter (VCounter),
      .frame    (frame)
   );

   assign start_rise = bus.startDesClock & ~start_q;
   assign grow_next  = {1'b0, radius} + {1'b0, STEP};

   assign dx = (HCounter >= cx) ? {1'b0, HCounter - cx} : {1'b0, cx - HCounter};
   assign dy = (VCounter >= cy) ? {1'b0, VCounter - cy} : {1'b0, cy - VCounter};
   assign d  = {1'b0, dx} + {1'b0, dy};

   assign on_ring = (state == GROW || state == SHRINK) &&
                    (d <= {2'b00, radius}) &&
                    ((d + {2'b00, RING_W}) > {2'b00, radius});

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         radius   <= '0;
         cx       <= '0;
         cy       <= '0;
         start_q  <= 1'b0;
         desclk_q <= 1'b0;
         busy_q   <= 1'b0;
         pixel    <= 1'b0;
      end else begin
         start_q <= bus.startDesClock;
         pixel   <= on_ring;
         case (state)
            IDLE: begin
               if (start_rise) begin
                  cx     <= clamp_coord(bus.dH, H_MAX);
                  cy     <= clamp_coord(bus.dV, V_MAX);
                  radius <= STEP;
                  busy_q <= 1'b1;
                  state  <= GROW;
               end
            end
            GROW: begin
               if (frame) begin
                  if (grow_next >= {1'b0, MAX_RADIUS}) begin
                     radius <= MAX_RADIUS;
                     state  <= SHRINK;
                  end else begin
                     radius <= grow_next[9:0];
                  end
               end
            end
            SHRINK: begin
               if (frame) begin
                  if (radius <= STEP) begin
                     radius   <= '0;
                     desclk_q <= 1'b1;
                     state    <= ACK;
                  end else begin
                     radius <= radius - STEP;
                  end
               end
            end
            ACK: begin
               if (!bus.startDesClock) begin
                  desclk_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.desClock = desclk_q;
   assign bus.busy     = busy_q;

endmodule
